// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM stage: access sizes, FSM states,
// lane offset width and byte-enable generation.
package mem_pkg;

    typedef enum logic [1:0] {
        SzByte  = 2'b00,
        SzHalf  = 2'b01,
        SzWord  = 2'b10,
        SzWordX = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDbg
    } state_e;

    localparam int unsigned MaxBeW = 64;

    function automatic int unsigned off_bits(int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    // Result is MaxBeW wide; callers keep the low be_w bits.
    function automatic logic [MaxBeW-1:0] be_gen(size_e size, int unsigned off,
                                                 int unsigned be_w);
        logic [MaxBeW:0] ones;
        ones = (65'd1 << be_w) - 65'd1;
        unique case (size)
            SzByte:  return 64'd1 << off;
            SzHalf:  return 64'd3 << off;
            default: return ones[MaxBeW-1:0];
        endcase
    endfunction

    function automatic logic misaligned(size_e size, int unsigned off);
        unique case (size)
            SzByte:  return 1'b0;
            SzHalf:  return off[0];
            default: return off != 0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge data-memory bus between the MEM stage and the data memory.
interface mem_access_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_align.sv
// Combinational load lane extraction with sign or zero extension.
module load_align
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OFF    = 2
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF-1:0]    off,
    input  size_e             size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] data
);
    logic [DATA_W-1:0] lane;
    logic              sign;

    always_comb begin
        lane = rdata >> {off, 3'b000};
        sign = 1'b0;
        data = rdata;
        unique case (size)
            SzByte: begin
                sign = !is_unsigned && lane[7];
                data = {{(DATA_W-8){sign}}, lane[7:0]};
            end
            SzHalf: begin
                sign = !is_unsigned && lane[15];
                data = {{(DATA_W-16){sign}}, lane[15:0]};
            end
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: sized loads/stores over a req/ack memory bus, misalignment
// trapping, debug memory reads and the MEM/WB pipeline register.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned WB_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [WB_W-1:0]     in_wb,
    input  logic                in_mem_rd,
    input  logic                in_mem_wr,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [DATA_W-1:0]   in_alu_result,
    input  logic [DATA_W-1:0]   in_reg_b,
    input  logic [REG_W-1:0]    in_wreg,
    output logic                stall,
    mem_access_stage_if.master  bus,
    input  logic                debug_on,
    input  logic [ADDR_W-1:0]   debug_addr,
    output logic [DATA_W-1:0]   debug_data,
    output logic                out_valid,
    output logic [WB_W-1:0]     out_wb,
    output logic [DATA_W-1:0]   out_wd,
    output logic [DATA_W-1:0]   out_alu_result,
    output logic [REG_W-1:0]    out_wreg,
    output logic                out_misalign
);
    localparam int unsigned OFF  = off_bits(DATA_W);
    localparam int unsigned BE_W = DATA_W / 8;

    state_e              state;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic                ld_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [WB_W-1:0]     wb_q;
    logic [REG_W-1:0]    wreg_q;
    logic [DATA_W-1:0]   alu_q;
    size_e               size_q;
    logic                uns_q;
    logic [OFF-1:0]      off_q;
    logic                dbg_out_q;

    logic [OFF-1:0]      in_off;
    size_e               in_sz;
    logic                in_mem;
    logic                in_mis;
    logic                in_go;
    logic [MaxBeW-1:0]   be_full;
    logic [BE_W-1:0]     in_be;
    logic [DATA_W-1:0]   in_wdata;
    logic [DATA_W-1:0]   ld_data;

    always_comb begin
        in_off   = in_alu_result[OFF-1:0];
        in_sz    = size_e'(in_size);
        in_mem   = in_valid && (in_mem_rd || in_mem_wr);
        in_mis   = in_mem && misaligned(in_sz, 32'(in_off));
        in_go    = in_mem && !in_mis;
        be_full  = be_gen(in_sz, 32'(in_off), BE_W);
        in_be    = be_full[BE_W-1:0];
        in_wdata = in_reg_b;
        unique case (in_sz)
            SzByte:  in_wdata = {BE_W{in_reg_b[7:0]}};
            SzHalf:  in_wdata = {(BE_W/2){in_reg_b[15:0]}};
            default: in_wdata = in_reg_b;
        endcase
    end

    load_align #(
        .DATA_W (DATA_W),
        .OFF    (OFF)
    ) u_load_align (
        .rdata       (bus.mem_rdata),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (ld_data)
    );

    // A debug read already issued keeps mem_req up until acked, even once debug_on drops.
    always_comb begin
        bus.mem_req   = (state == StReq) || ((state == StDbg) && (debug_on || dbg_out_q));
        bus.mem_we    = (state == StReq) && we_q;
        bus.mem_addr  = (state == StDbg) ? debug_addr : addr_q;
        bus.mem_be    = (state == StReq) ? be_q : '0;
        bus.mem_wdata = wdata_q;
        stall         = 1'b0;
        if (rst) begin
            unique case (state)
                StIdle:  stall = debug_on || in_go;
                StReq:   stall = !bus.mem_ack;
                default: stall = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= StIdle;
            addr_q         <= '0;
            we_q           <= 1'b0;
            ld_q           <= 1'b0;
            be_q           <= '0;
            wdata_q        <= '0;
            wb_q           <= '0;
            wreg_q         <= '0;
            alu_q          <= '0;
            size_q         <= SzByte;
            uns_q          <= 1'b0;
            off_q          <= '0;
            dbg_out_q      <= 1'b0;
            debug_data     <= '0;
            out_valid      <= 1'b0;
            out_wb         <= '0;
            out_wd         <= '0;
            out_alu_result <= '0;
            out_wreg       <= '0;
            out_misalign   <= 1'b0;
        end else begin
            // Bubble unless an instruction completes below.
            out_valid      <= 1'b0;
            out_wb         <= '0;
            out_wd         <= '0;
            out_alu_result <= '0;
            out_wreg       <= '0;
            out_misalign   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (debug_on) begin
                        state     <= StDbg;
                        dbg_out_q <= 1'b0;
                    end else if (in_go) begin
                        state   <= StReq;
                        addr_q  <= in_alu_result[ADDR_W+OFF-1:OFF];
                        we_q    <= in_mem_wr;
                        ld_q    <= in_mem_rd && !in_mem_wr;
                        be_q    <= in_be;
                        wdata_q <= in_wdata;
                        wb_q    <= in_wb;
                        wreg_q  <= in_wreg;
                        alu_q   <= in_alu_result;
                        size_q  <= in_sz;
                        uns_q   <= in_unsigned;
                        off_q   <= in_off;
                    end else if (in_valid) begin
                        out_valid      <= 1'b1;
                        out_wb         <= in_mis ? '0 : in_wb;
                        out_alu_result <= in_alu_result;
                        out_wreg       <= in_wreg;
                        out_misalign   <= in_mis;
                    end
                end
                StReq: begin
                    if (bus.mem_ack) begin
                        out_valid      <= 1'b1;
                        out_wb         <= wb_q;
                        out_wd         <= ld_q ? ld_data : '0;
                        out_alu_result <= alu_q;
                        out_wreg       <= wreg_q;
                        dbg_out_q      <= 1'b0;
                        state          <= debug_on ? StDbg : StIdle;
                    end
                end
                StDbg: begin
                    if (bus.mem_req && bus.mem_ack) debug_data <= bus.mem_rdata;
                    dbg_out_q <= bus.mem_req && !bus.mem_ack;
                    if (!debug_on && (!dbg_out_q || bus.mem_ack)) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a byte-array reference model,
// with a wait-state memory responder.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_mem_rd, in_mem_wr, in_unsigned;
    logic [1:0]  in_wb, in_size;
    logic [31:0] in_alu_result, in_reg_b;
    logic [4:0]  in_wreg;
    logic        stall, debug_on;
    logic [9:0]  debug_addr;
    logic [31:0] debug_data, out_wd, out_alu_result;
    logic        out_valid, out_misalign;
    logic [1:0]  out_wb;
    logic [4:0]  out_wreg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage_if #(.DATA_W(32), .ADDR_W(10)) bus ();

    mem_access_stage #(
        .DATA_W (32),
        .ADDR_W (10),
        .REG_W  (5),
        .WB_W   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_wb          (in_wb),
        .in_mem_rd      (in_mem_rd),
        .in_mem_wr      (in_mem_wr),
        .in_size        (in_size),
        .in_unsigned    (in_unsigned),
        .in_alu_result  (in_alu_result),
        .in_reg_b       (in_reg_b),
        .in_wreg        (in_wreg),
        .stall          (stall),
        .bus            (bus),
        .debug_on       (debug_on),
        .debug_addr     (debug_addr),
        .debug_data     (debug_data),
        .out_valid      (out_valid),
        .out_wb         (out_wb),
        .out_wd         (out_wd),
        .out_alu_result (out_alu_result),
        .out_wreg       (out_wreg),
        .out_misalign   (out_misalign)
    );

    // Memory responder: ack after lat_cfg wait cycles (0 = same cycle).
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    int lat_cfg = 0;
    int cnt     = 0;

    always_comb begin
        bus.mem_ack   = bus.mem_req && (cnt >= lat_cfg);
        bus.mem_rdata = mem[bus.mem_addr];
    end

    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_ack) cnt <= cnt + 1;
        else cnt <= 0;
        if (bus.mem_req && bus.mem_ack && bus.mem_we)
            for (int i = 0; i < 4; i++)
                if (bus.mem_be[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input logic v, input logic [1:0] wb, input logic [31:0] wd,
                              input logic [31:0] alu, input logic [4:0] wreg, input logic mis);
        check_eq("out_valid", out_valid, v);
        check_eq("out_wb", out_wb, wb);
        check_eq("out_wd", out_wd, wd);
        check_eq("out_alu", out_alu_result, alu);
        check_eq("out_wreg", out_wreg, wreg);
        check_eq("out_misalign", out_misalign, mis);
    endtask

    // Presents one instruction and follows it to completion; returns 1 ns after the
    // edge that loads MEM/WB so callers can inspect the registered outputs.
    task automatic run_instr(input logic v, input logic rd, input logic wr,
                             input logic [1:0] sz, input logic un, input logic [31:0] addr,
                             input logic [31:0] b, input int lat);
        logic [4:0]  wreg;
        logic [1:0]  wb;
        logic [9:0]  word;
        logic [3:0]  ebe;
        logic [31:0] ewdata, eload, mask;
        logic        memop, mis, done;
        int          nb, off, cycles;
        wreg = 5'($urandom);
        wb   = 2'($urandom);
        @(negedge clk);
        in_valid = v; in_mem_rd = rd; in_mem_wr = wr; in_size = sz; in_unsigned = un;
        in_alu_result = addr; in_reg_b = b; in_wreg = wreg; in_wb = wb; lat_cfg = lat;
        nb     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off    = int'(addr[1:0]);
        word   = addr[11:2];
        memop  = v && (rd || wr);
        mis    = memop && ((off % nb) != 0);
        ebe    = 4'(((1 << nb) - 1) << off);
        ewdata = (nb == 1) ? {24'd0, b[7:0]} * 32'h0101_0101 :
                 (nb == 2) ? {16'd0, b[15:0]} * 32'h0001_0001 : b;
        #1;
        if (!memop || mis) begin
            check_eq("idle_stall", stall, 1'b0);
            check_eq("idle_req", bus.mem_req, 1'b0);
            @(posedge clk); #1;
            check_outs(v, (v && !mis) ? wb : 2'd0, 32'd0, v ? addr : 32'd0,
                       v ? wreg : 5'd0, mis);
        end else begin
            check_eq("acc_stall", stall, 1'b1);
            cycles = 0;
            done   = 1'b0;
            while (!done && cycles < 20) begin
                @(negedge clk); #1;
                cycles++;
                check_eq("req", bus.mem_req, 1'b1);
                check_eq("addr", bus.mem_addr, word);
                check_eq("we", bus.mem_we, wr);
                if (wr) begin
                    check_eq("be", bus.mem_be, ebe);
                    check_eq("wdata", bus.mem_wdata, ewdata);
                end
                check_eq("bubble", out_valid, 1'b0);
                done = bus.mem_ack;
                check_eq("req_stall", stall, !done);
            end
            check_eq("acc_done", done, 1'b1);
            check_eq("req_cycles", cycles, lat + 1);
            mask  = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
            eload = (ref_mem[word] >> (8 * off)) & mask;
            if (!un && nb < 4 && eload[8*nb-1]) eload = eload | ~mask;
            if (wr)
                for (int i = 0; i < 4; i++)
                    if (ebe[i]) ref_mem[word][8*i +: 8] = ewdata[8*i +: 8];
            @(posedge clk); #1;
            check_outs(1'b1, wb, (rd && !wr) ? eload : 32'd0, addr, wreg, 1'b0);
        end
    endtask

    logic        r_v, r_rd, r_wr, r_un;
    logic [1:0]  r_sz;
    logic [31:0] r_addr;
    int          k, cycles;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        in_valid = 0; in_mem_rd = 0; in_mem_wr = 0; in_size = 0; in_unsigned = 0;
        in_alu_result = 0; in_reg_b = 0; in_wreg = 0; in_wb = 0;
        debug_on = 0; debug_addr = 0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_req", bus.mem_req, 1'b0);
        check_eq("rst_debug_data", debug_data, 32'd0);
        check_outs(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk) rst = 1'b1;

        // SB 0xAABBCCDD at 0x103, ack in the first request cycle
        run_instr(1, 0, 1, 2'd0, 0, 32'h103, 32'hAABB_CCDD, 0);
        check_eq("sb_mem", mem[10'h40][31:24], 8'hDD);

        // LB at 0x2 from word 0x00800000, signed then unsigned
        mem[0] = 32'h0080_0000; ref_mem[0] = 32'h0080_0000;
        run_instr(1, 1, 0, 2'd0, 0, 32'h2, 32'd0, 1);
        check_eq("lb_signed", out_wd, 32'hFFFF_FF80);
        run_instr(1, 1, 0, 2'd0, 1, 32'h2, 32'd0, 0);
        check_eq("lb_unsigned", out_wd, 32'h0000_0080);

        // LW at 0x8 with three wait cycles, then misaligned LH at 0x1
        run_instr(1, 1, 0, 2'd2, 0, 32'h8, 32'd0, 3);
        run_instr(1, 1, 0, 2'd1, 0, 32'h1, 32'd0, 0);
        check_eq("lh_mis", out_misalign, 1'b1);
        // load+store together: store wins, no load data
        run_instr(1, 1, 1, 2'd2, 0, 32'h20, 32'h1357_9BDF, 1);

        // Debug raised during a pending LW
        mem[5] = 32'h1234_5678; ref_mem[5] = 32'h1234_5678;
        @(negedge clk);
        in_valid = 1; in_mem_rd = 1; in_mem_wr = 0; in_size = 2'd2; in_unsigned = 0;
        in_alu_result = 32'h10; in_wb = 2'd3; in_wreg = 5'd7; lat_cfg = 3;
        @(negedge clk);
        debug_on = 1; debug_addr = 10'h05;
        cycles = 1;
        #1;
        while (!bus.mem_ack && cycles < 20) begin
            check_eq("dbg_hold_stall", stall, 1'b1);
            check_eq("dbg_hold_addr", bus.mem_addr, 10'h4);
            @(negedge clk); #1;
            cycles++;
        end
        check_eq("dbg_req_cycles", cycles, 4);
        @(posedge clk); #1;
        check_outs(1'b1, 2'd3, ref_mem[4], 32'h10, 5'd7, 1'b0);
        lat_cfg = 1;
        repeat (6) begin
            @(negedge clk);
            in_valid = 0; in_mem_rd = 0;
            #1;
            check_eq("dbg_stall", stall, 1'b1);
            check_eq("dbg_addr", bus.mem_addr, 10'h5);
            check_eq("dbg_we", bus.mem_we, 1'b0);
        end
        check_eq("dbg_data", debug_data, 32'h1234_5678);
        @(negedge clk);
        debug_on = 0;
        cycles = 0;
        #1;
        while (stall && cycles < 10) begin
            @(negedge clk); #1;
            cycles++;
        end
        check_eq("dbg_exit", stall, 1'b0);

        // Reset while a request is outstanding
        @(negedge clk);
        in_valid = 1; in_mem_rd = 1; in_mem_wr = 0; in_size = 2'd2; in_alu_result = 32'h40;
        lat_cfg = 5;
        @(negedge clk); #1;
        check_eq("pre_rst_req", bus.mem_req, 1'b1);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_req", bus.mem_req, 1'b0);
        check_eq("mid_rst_stall", stall, 1'b0);
        check_eq("mid_rst_debug_data", debug_data, 32'd0);
        check_outs(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        in_valid = 0;
        rst = 1'b1;
        #1;
        check_eq("post_rst_req", bus.mem_req, 1'b0);
        run_instr(1, 1, 0, 2'd1, 1, 32'h22, 32'd0, 2);

        for (int n = 0; n < 200; n++) begin
            r_v    = ($urandom_range(0, 7) != 0);
            k      = $urandom_range(0, 5);
            r_rd   = (k == 1) || (k == 3) || (k == 4);
            r_wr   = (k == 2) || (k == 3) || (k == 5);
            r_sz   = 2'($urandom);
            r_un   = 1'($urandom);
            r_addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            run_instr(r_v, r_rd, r_wr, r_sz, r_un, r_addr, $urandom, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised MEM stage of the MIPS pipeline, replacing the fixed 32-bit word-only stage. Sits between the EX/MEM register and write-back. Drives an external data memory through a request/acknowledge handshake with arbitrary wait states, and supports byte/halfword/word loads and stores with sign or zero extension. Adds misalignment detection, a pipeline stall output, and a debug read port, then registers the MEM/WB bundle.

## Interface
Parameters:
- DATA_W, 32, datapath width; multiple of 8, power of two.
- ADDR_W, 10, word-address width of the data memory.
- REG_W, 5, register-file index width.
- WB_W, 2, width of the write-back control bundle.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  EX/MEM slot holds an instruction.
- in_wb  in  WB_W  write-back control.
- in_mem_rd / in_mem_wr  in  1  load / store.
- in_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- in_unsigned  in  1  zero-extend loads.
- in_alu_result  in  DATA_W  effective byte address.
- in_reg_b  in  DATA_W  store data.
- in_wreg  in  REG_W  destination register.
- stall  out  1  upstream must hold its inputs.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  lane-aligned store data.
- mem_be  out  DATA_W/8  byte enables.
- mem_rdata  in  DATA_W  read data; valid with mem_ack.
- mem_ack  in  1  access complete.
- debug_on  in  1  freeze pipeline and read memory for the debug unit.
- debug_addr  in  ADDR_W  debug word address.
- debug_data  out  DATA_W  last debug read, registered.
- out_valid, out_wb, out_wd (load data), out_alu_result, out_wreg, out_misalign  out  MEM/WB register.

## Operation
- OFF = log2(DATA_W/8). Byte offset = in_alu_result[OFF-1:0]. mem_addr = in_alu_result[ADDR_W+OFF-1:OFF]. Little-endian lanes.
- Stores:
  - Byte: data replicated across all lanes, be = 1<<off.
  - Half: data replicated, be = 2'b11<<off.
  - Word: be all ones.
- Loads: extract the selected lane(s); sign-extend unless in_unsigned.
- Misalignment:
  - A half access with off[0]=1 is misaligned.
  - A word access with off≠0 is misaligned.
  - On misalignment: no memory request, out_misalign=1, out_wb forced to 0, passes in one cycle.
- in_mem_rd and in_mem_wr both high: the store is performed; out_wd=0.
- FSM states IDLE, REQ, DBG:
  - In IDLE with debug_on=1: go to DBG.
  - In IDLE with a valid, aligned access: capture the request, go to REQ, stall=1.
  - In IDLE with a non-memory or misaligned instruction: MEM/WB updated next edge, no stall.
  - In REQ: mem_req=1 with stable addr/we/be/wdata until mem_ack. On ack: MEM/WB loads (out_wd = extended mem_rdata for loads, 0 for stores), then go to DBG if debug_on else IDLE. stall = !mem_ack.
  - In DBG: stall=1; mem_req=1, mem_we=0, mem_addr=debug_addr; every ack registers mem_rdata into debug_data. Exit to IDLE on the first cycle with debug_on=0 and no outstanding ack.
- out_valid=0 on cycles where no instruction completes (bubble).

## Timing
- Reset (rst low, async): state IDLE; every output and register 0 (mem_req, stall, out_*, debug_data).
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory access: 1 + N cycles, where N = cycles in REQ including the ack cycle (minimum 1, when ack returns combinationally in the first REQ cycle).
- Throughput: back-to-back accesses lose no cycle beyond the handshake. The cycle after an ack, IDLE may accept the next instruction.
- debug_on asserted during REQ: the access completes normally first; no request is dropped.
- Reset during REQ: request abandoned; memory must tolerate it.

## Structure
- Package mem_pkg: size encodings, FSM state enum, OFF derivation, byte-enable generation function.
- Sub-module load_align: combinational lane extract + sign/zero extension, reused by the debug unit's disassembler path.

## Test plan
- SB 0xAABBCCDD at address 0x103, ack same cycle → mem_be=1000, mem_wdata=0xDDDDDDDD, mem_addr=0x40, stall for 1 cycle.
- LB at address 0x2 with word 0x00800000, signed → out_wd=0xFFFFFF80; same with unsigned → 0x00000080.
- LW at address 0x8 with ack after 3 wait cycles → mem_req held 4 cycles, stall=1 throughout, out_wd valid the edge after ack.
- LH at address 0x1 → no mem_req, out_misalign=1, out_wb=0, latency 1.
- debug_on raised mid-REQ, debug_addr=0x05 holding 0x12345678 → pending access completes, then debug_data=0x12345678, stall stays 1 until debug_on drops.
- rst low during REQ → mem_req and stall 0 immediately, all outputs 0, state IDLE after release.
